// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns a fixed-latency FIFO read port into a valid/ready stream.
// Reads are issued only when the small output buffer is guaranteed to have room
// for the word when it lands two cycles later, so the buffer can never overflow.
//
// Stream handshake: a word transfers on every posedge where m_valid=1 and
// m_ready=1. m_valid never drops and m_data never changes until that happens.
//
// state encoding (debug output): 0 = IDLE, 1 = RUN, 2 = DRAIN.
module fifo_rd_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int BUF_DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  empty,
   input  logic [DATA_WIDTH-1:0] data_out,
   output logic                  r_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  busy,
   output logic [15:0]           rd_count,
   output logic [1:0]            state
);

   localparam int PTR_W = (BUF_DEPTH > 2) ? 2 : 1;
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                cur_st;
   state_t                nxt_st;
   logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
   logic [PTR_W-1:0]      head;
   logic [PTR_W-1:0]      tail;
   logic [CNT_W-1:0]      buf_cnt;
   logic [CNT_W-1:0]      occ_after;
   logic                  inflight;
   logic                  capture;
   logic                  pop;

   // Pointers wrap at BUF_DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(BUF_DEPTH - 1)) begin
         return '0;
      end
      return p + PTR_W'(1);
   endfunction

   // A word read last cycle is on data_out now and is written at the tail.
   assign capture   = inflight;
   assign pop       = m_valid & m_ready;
   // Entries still committed at the end of this cycle; a new read needs one more.
   assign occ_after = buf_cnt + CNT_W'(inflight) - CNT_W'(pop);
   // Gated by rst so no read can be issued while reset is held.
   assign r_en      = rst & en & ~empty & (occ_after < CNT_W'(BUF_DEPTH));
   assign m_valid   = (buf_cnt != '0);
   assign m_data    = m_valid ? buf_mem[head] : '0;
   assign busy      = m_valid | inflight;

   // Buffer bookkeeping: read-in-flight flag, pointers, occupancy, pop counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inflight <= 1'b0;
         head     <= '0;
         tail     <= '0;
         buf_cnt  <= '0;
         rd_count <= '0;
      end else begin
         inflight <= r_en;
         if (capture) begin
            tail <= ptr_inc(tail);
         end
         if (pop) begin
            head     <= ptr_inc(head);
            rd_count <= rd_count + 16'd1;
         end
         case ({capture, pop})
            2'b10:   buf_cnt <= buf_cnt + CNT_W'(1);
            2'b01:   buf_cnt <= buf_cnt - CNT_W'(1);
            default: buf_cnt <= buf_cnt;
         endcase
      end
   end

   // Buffer storage; contents are only observed through m_data when m_valid=1.
   always_ff @(posedge clk) begin
      if (capture) begin
         buf_mem[tail] <= data_out;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_st <= ST_IDLE;
      end else begin
         cur_st <= nxt_st;
      end
   end

   // FSM next-state: enable starts a run, dropping it drains whatever is still busy.
   always_comb begin
      nxt_st = cur_st;
      case (cur_st)
         ST_IDLE: begin
            if (en) nxt_st = ST_RUN;
         end
         ST_RUN: begin
            if (!en) nxt_st = busy ? ST_DRAIN : ST_IDLE;
         end
         ST_DRAIN: begin
            if (en)         nxt_st = ST_RUN;
            else if (!busy) nxt_st = ST_IDLE;
         end
         default: nxt_st = ST_IDLE;
      endcase
   end

   // FSM outputs: the state itself is the only FSM-driven output.
   always_comb begin
      state = cur_st;
   end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a FIFO source model feeds the DUT, a timeline model
// (each read word becomes deliverable two cycles after its read) predicts the
// stream outputs every cycle, and directed tests pin literal values.
module tb_fifo_rd_stream;

   localparam int         DW      = 8;
   localparam int         DEPTH   = 3;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic          clk      = 1'b0;
   logic          rst      = 1'b0;
   logic          en       = 1'b0;
   logic          empty    = 1'b1;
   logic [DW-1:0] data_out = 8'hEE;
   logic          m_ready  = 1'b0;
   logic          r_en;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          busy;
   logic [15:0]   rd_count;
   logic [1:0]    state;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [DW-1:0] w;
      int            avail;
   } ent_t;

   ent_t          mdl_q[$];
   logic [DW-1:0] src_q[$];
   int            cyc       = 0;
   logic          r_en_s    = 1'b0;
   logic          pop_s     = 1'b0;
   logic          busy_s    = 1'b0;
   logic          en_s      = 1'b0;
   logic [15:0]   exp_cnt   = 16'd0;
   logic [1:0]    exp_state = S_IDLE;

   fifo_rd_stream #(
      .DATA_WIDTH(DW),
      .BUF_DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .empty    (empty),
      .data_out (data_out),
      .r_en     (r_en),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .busy     (busy),
      .rd_count (rd_count),
      .state    (state)
   );

   // clock / reset block
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push_word(input logic [DW-1:0] w);
      src_q.push_back(w);
   endtask

   task automatic wait_count(input string name, input logic [15:0] target, input int bound);
      int k;
      k = 0;
      while (rd_count !== target && k < bound) begin
         @(negedge clk);
         k++;
      end
      check(name, rd_count, target);
   endtask

   // Compare process: predicts every output from the delivery timeline each cycle.
   always @(negedge clk) begin : cmp
      int   n_av;
      int   n_pd;
      logic ev;
      logic ep;
      logic er;
      logic eb;
      if (!rst) begin
         check("rst_r_en", r_en, 0);
         check("rst_m_valid", m_valid, 0);
         check("rst_m_data", m_data, 0);
         check("rst_busy", busy, 0);
         check("rst_rd_count", rd_count, 0);
         check("rst_state", state, S_IDLE);
         r_en_s = 1'b0;
         pop_s  = 1'b0;
         busy_s = 1'b0;
         en_s   = 1'b0;
      end else begin
         n_av = 0;
         n_pd = 0;
         foreach (mdl_q[i]) begin
            if (mdl_q[i].avail <= cyc) n_av++;
            else if (mdl_q[i].avail == cyc + 1) n_pd++;
         end
         ev = (n_av > 0);
         ep = ev & m_ready;
         eb = (n_av + n_pd) > 0;
         er = en & ~empty & ((n_av + n_pd - (ep ? 1 : 0)) < DEPTH);
         check("r_en", r_en, er);
         check("m_valid", m_valid, ev);
         if (ev) check("m_data", m_data, mdl_q[0].w);
         check("busy", busy, eb);
         check("rd_count", rd_count, exp_cnt);
         check("state", state, exp_state);
         check("no_overflow", n_av <= DEPTH, 1);
         r_en_s = r_en;
         pop_s  = ep;
         busy_s = eb;
         en_s   = en;
      end
   end

   // FIFO source and model update, just after each active edge.
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         mdl_q.delete();
         exp_cnt   = 16'd0;
         exp_state = S_IDLE;
         data_out  = 8'hEE;
      end else begin
         if (pop_s) begin
            void'(mdl_q.pop_front());
            exp_cnt = exp_cnt + 16'd1;
         end
         if (r_en_s && src_q.size() > 0) begin
            data_out = src_q.pop_front();
            mdl_q.push_back('{w: data_out, avail: cyc + 2});
         end else begin
            data_out = 8'hE0 ^ DW'(cyc);
         end
         case (exp_state)
            S_IDLE:  if (en_s) exp_state = S_RUN;
            S_RUN:   if (!en_s) exp_state = busy_s ? S_DRAIN : S_IDLE;
            S_DRAIN: begin
               if (en_s)         exp_state = S_RUN;
               else if (!busy_s) exp_state = S_IDLE;
            end
            default: exp_state = S_IDLE;
         endcase
      end
      empty = (src_q.size() == 0);
      cyc++;
   end

   // Driver: directed scenarios with literal expectations.
   initial begin : stim
      int nr;
      int k;
      repeat (2) tick();
      rst = 1'b1;
      @(negedge clk);
      check("t0_rd_count", rd_count, 16'h0000);
      check("t0_state", state, S_IDLE);

      // Three-word stream at full rate.
      push_word(8'h11); push_word(8'h22); push_word(8'h33);
      tick();
      en = 1'b1; m_ready = 1'b1;
      @(negedge clk); check("t1_ren_c0", r_en, 1); check("t1_valid_c0", m_valid, 0);
      @(negedge clk); check("t1_ren_c1", r_en, 1); check("t1_valid_c1", m_valid, 0);
      @(negedge clk); check("t1_ren_c2", r_en, 1); check("t1_data_c2", m_data, 8'h11);
      @(negedge clk); check("t1_ren_c3", r_en, 0); check("t1_data_c3", m_data, 8'h22);
      @(negedge clk); check("t1_data_c4", m_data, 8'h33);
      @(negedge clk); check("t1_rd_count", rd_count, 16'd3); check("t1_valid_end", m_valid, 0);
      tick();
      en = 1'b0;

      // Backpressure: reads stop once the buffer is committed, head is held.
      m_ready = 1'b0;
      push_word(8'hA1); push_word(8'hA2); push_word(8'hA3); push_word(8'hA4); push_word(8'hA5);
      tick();
      en = 1'b1;
      nr = 0;
      repeat (8) begin
         @(negedge clk);
         if (r_en) nr++;
      end
      check("t2_reads", nr, DEPTH);
      check("t2_hold_data", m_data, 8'hA1);
      check("t2_hold_count", rd_count, 16'd3);
      tick();
      m_ready = 1'b1;
      wait_count("t2_all_delivered", 16'd8, 30);
      tick();
      check("t2_idle_valid", m_valid, 0);

      // Empty guard.
      en = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check("t3_ren", r_en, 0);
         check("t3_valid", m_valid, 0);
         check("t3_busy", busy, 0);
      end
      tick();
      en = 1'b0;

      // Drain: enable dropped right after one read.
      push_word(8'h5A); push_word(8'h6B);
      tick();
      en = 1'b1;
      @(negedge clk); check("t4_ren", r_en, 1);
      tick();
      en = 1'b0;
      @(negedge clk); check("t4_no_ren", r_en, 0); check("t4_busy", busy, 1);
      @(negedge clk); check("t4_valid", m_valid, 1); check("t4_data", m_data, 8'h5A);
      @(negedge clk); check("t4_busy_low", busy, 0); check("t4_ren_low", r_en, 0);
      @(negedge clk); check("t4_state", state, S_IDLE);

      // Reset with two buffered words and one read in flight.
      m_ready = 1'b0;
      push_word(8'h71); push_word(8'h72); push_word(8'h73); push_word(8'h74);
      tick();
      en = 1'b1;
      repeat (4) @(negedge clk);
      check("t5_busy", busy, 1);
      check("t5_head", m_data, 8'h6B);
      check("t5_ren", r_en, 0);
      #1 rst = 1'b0;
      #1;
      check("t5_now_ren", r_en, 0);
      check("t5_now_valid", m_valid, 0);
      check("t5_now_data", m_data, 0);
      check("t5_now_busy", busy, 0);
      check("t5_now_count", rd_count, 0);
      check("t5_now_state", state, S_IDLE);
      repeat (2) tick();
      rst = 1'b1;
      m_ready = 1'b1;
      k = 0;
      while (!m_valid && k < 10) begin
         @(negedge clk);
         k++;
      end
      check("t5_first_valid", m_valid, 1);
      check("t5_first_word", m_data, 8'h73);
      wait_count("t5_count", 16'd2, 10);
      tick();
      en = 1'b0;

      // Counter wrap at sustained full rate.
      rst = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      @(negedge clk);
      check("t6_count_zero", rd_count, 0);
      for (int i = 0; i < 65535; i++) push_word(DW'(i));
      tick();
      en = 1'b1;
      repeat (65538) @(negedge clk);
      check("t6_count_max", rd_count, 16'hFFFF);
      check("t6_valid_gap", m_valid, 0);
      push_word(8'h99);
      repeat (3) @(negedge clk);
      check("t6_last_word", m_data, 8'h99);
      repeat (3) @(negedge clk);
      check("t6_count_wrap", rd_count, 16'h0000);
      tick();
      en = 1'b0;
      repeat (3) tick();

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
